stage_reg: RTL and testbench
============================

# stage_reg

Parametrised fetch-to-decode pipeline stage register with a valid/ready handshake and a one-entry skid buffer. It replaces enable-based stalling with back-pressure, so upstream ready comes straight from a flop and the stall path does not combinationally chain across stages. It also provides synchronous flush, occupancy, and a saturating bubble counter for performance monitoring. It sits between the fetch and decode stages of the pipelined MIPS core, and is reusable between any two stages.

## Interface
- INSTR_W, default 32: instruction payload width.
- PC_W, default 32: PC+4 payload width.
- CNT_W, default 16: bubble counter width.

- STAGE_REG_CLK, in, 1: single clock; all state updates on its rising edge.
- STAGE_REG_RST, in, 1: reset, synchronous, active-high.
- STAGE_REG_FLUSH, in, 1: synchronous clear of all held entries.
- STAGE_REG_IN_VALID, in, 1: upstream presents a payload.
- STAGE_REG_IN_READY, out, 1: stage can accept; driven directly from a flop.
- STAGE_REG_IN_INSTR, in, INSTR_W: instruction from fetch.
- STAGE_REG_IN_PCPLUS4, in, PC_W: PC+4 from fetch.
- STAGE_REG_OUT_VALID, out, 1: main entry holds a payload.
- STAGE_REG_OUT_READY, in, 1: downstream accepts.
- STAGE_REG_OUT_INSTR, out, INSTR_W: instruction to decode.
- STAGE_REG_OUT_PCPLUS4, out, PC_W: PC+4 to decode.
- STAGE_REG_OCC, out, 2: number of held entries, 0 to 2.
- STAGE_REG_BUBBLES, out, CNT_W: saturating count of cycles with OUT_VALID low.

## Operation
- Storage:
  - Main entry drives the OUT_* ports.
  - Skid entry holds one extra payload.
- Transfer conditions:
  - in_fire = IN_VALID & IN_READY.
  - out_fire = OUT_VALID & OUT_READY.
- States, encoded by occupancy:
  - EMPTY: OCC=0.
  - ONE: OCC=1, main entry valid.
  - FULL: OCC=2, main and skid entries valid.
- IN_READY is 1 in EMPTY and ONE, and 0 in FULL.
- Transitions:
  - EMPTY + in_fire: main ← input; go to ONE.
  - ONE + in_fire + out_fire: main ← input; stay in ONE.
  - ONE + in_fire only: skid ← input; go to FULL.
  - ONE + out_fire only: go to EMPTY; main data holds its last value.
  - FULL + out_fire: main ← skid; go to ONE. Input is not accepted because IN_READY=0.
  - In all other cases, state and data hold.
- Priority: RST > FLUSH > normal handshake.
- FLUSH:
  - Next state is EMPTY; main and skid data are zeroed.
  - An in_fire in the same cycle is dropped.
  - An out_fire in the same cycle counts as a completed transfer, since downstream sampled it.
- BUBBLES:
  - Increments in every non-reset cycle where OUT_VALID=0, including the cycle a flush is asserted if the stage is already empty.
  - Saturates at all-ones and never wraps.
  - Cleared only by RST.
- Ordering: payloads leave in acceptance order. No loss or duplication apart from flush drops.

## Timing
- Reset values, one cycle after RST is sampled high: OUT_VALID=0, IN_READY=1, OCC=0, OUT_INSTR=0, OUT_PCPLUS4=0, BUBBLES=0, skid data 0.
- RST asserted mid-operation discards all entries at the next edge, regardless of FLUSH or the handshake.
- Latency: an input accepted at edge N appears on OUT_* with OUT_VALID=1 after edge N (one cycle) when the stage was EMPTY, or ONE with out_fire.
- Throughput: one transfer per cycle with OUT_READY held high.
- IN_READY falls on the edge that enters FULL and rises on the edge that leaves FULL. It never depends combinationally on OUT_READY.
- OUT_* payload is stable while OUT_VALID=1 and OUT_READY=0.
- Upstream must hold IN_* stable while IN_VALID=1 and IN_READY=0. The stage does not check this.
- OCC and BUBBLES are registered and update on the same edge as the state.

## Structure
- Shared package stage_reg_pkg:
  - occupancy state encoding (EMPTY=2'd0, ONE=2'd1, FULL=2'd2);
  - default widths.
- One natural sub-module: sat_counter (CNT_W, synchronous active-high clear, increment enable, saturate at max). It is reused by other pipeline performance counters.
- The stage_reg body holds the main entry, skid entry, state flops, and next-state logic.

## Test plan
- Reset: assert RST 2 cycles with IN_VALID=1 → OUT_VALID=0, OCC=0, IN_READY=1, OUT_INSTR=0, BUBBLES=0.
- Streaming: OUT_READY=1, push 0x20080005/0x4, 0x20090007/0x8, 0x01095020/0xC on consecutive cycles → each appears exactly one cycle later, in order; OCC stays 1; IN_READY stays 1.
- Back-pressure: OUT_READY=0, push A=0x11111111 then B=0x22222222 → OCC=2, IN_READY=0, C is not accepted, OUT_INSTR=A held. Release OUT_READY → A, B, then C delivered, none lost.
- Flush with traffic: OCC=2 and IN_VALID=1 with FLUSH=1 for one cycle → next cycle OCC=0, OUT_VALID=0, OUT_INSTR=0, OUT_PCPLUS4=0. The pending input is not delivered. IN_READY=1.
- Simultaneous events: RST and FLUSH both high with in_fire → reset values. In ONE, in_fire + out_fire → OCC remains 1 and the new payload is on the outputs.
- Bubble saturation: CNT_W=4, idle 20 cycles → BUBBLES climbs to 15 and holds at 15. Valid traffic freezes it. RST clears it to 0.

Source files
------------

// File: rtl/stage_reg_pkg.sv
// -----------------------------------------------------------------------------
// stage_reg_pkg
// Shared definitions for the pipeline stage register and its helpers:
//   - occ_state_t : occupancy-encoded state (EMPTY=0, ONE=1, FULL=2)
//   - DEF_*_W     : default payload and counter widths
// -----------------------------------------------------------------------------
package stage_reg_pkg;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } occ_state_t;

   localparam int DEF_INSTR_W = 32;
   localparam int DEF_PC_W    = 32;
   localparam int DEF_CNT_W   = 16;

endpackage

// File: rtl/sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Saturating up-counter for performance monitoring.
// Ports:
//   i_clk   : clock, rising edge
//   i_clr   : synchronous active-high clear (highest priority)
//   i_inc   : increment enable
//   o_count : current count; sticks at all-ones, never wraps
// -----------------------------------------------------------------------------
module sat_counter
   import stage_reg_pkg::*;
#(
   parameter int CNT_W = DEF_CNT_W
) (
   input  logic             i_clk,
   input  logic             i_clr,
   input  logic             i_inc,
   output logic [CNT_W-1:0] o_count
);

   logic [CNT_W-1:0] r_count;
   logic             w_at_max;

   assign w_at_max = &r_count;

   always_ff @(posedge i_clk) begin
      if (i_clr) begin
         r_count <= '0;
      end else if (i_inc && !w_at_max) begin
         r_count <= r_count + 1'b1;
      end
   end

   assign o_count = r_count;

endmodule

// File: rtl/stage_reg.sv
// -----------------------------------------------------------------------------
// stage_reg
// Pipeline stage register with valid/ready handshake and a one-entry skid
// buffer. Upstream ready is a flop, so a stall never chains combinationally
// across stages. Provides synchronous flush, occupancy and a saturating
// bubble counter (cycles with no valid output).
// Ports:
//   STAGE_REG_CLK / STAGE_REG_RST   : clock, synchronous active-high reset
//   STAGE_REG_FLUSH                 : synchronous clear of held entries
//   STAGE_REG_IN_*                  : upstream valid/ready + payload
//   STAGE_REG_OUT_*                 : downstream valid/ready + payload
//   STAGE_REG_OCC                   : held entries (0..2)
//   STAGE_REG_BUBBLES               : saturating count of OUT_VALID=0 cycles
// -----------------------------------------------------------------------------
module stage_reg
   import stage_reg_pkg::*;
#(
   parameter int INSTR_W = DEF_INSTR_W,
   parameter int PC_W    = DEF_PC_W,
   parameter int CNT_W   = DEF_CNT_W
) (
   input  logic               STAGE_REG_CLK,
   input  logic               STAGE_REG_RST,
   input  logic               STAGE_REG_FLUSH,
   input  logic               STAGE_REG_IN_VALID,
   output logic               STAGE_REG_IN_READY,
   input  logic [INSTR_W-1:0] STAGE_REG_IN_INSTR,
   input  logic [PC_W-1:0]    STAGE_REG_IN_PCPLUS4,
   output logic               STAGE_REG_OUT_VALID,
   input  logic               STAGE_REG_OUT_READY,
   output logic [INSTR_W-1:0] STAGE_REG_OUT_INSTR,
   output logic [PC_W-1:0]    STAGE_REG_OUT_PCPLUS4,
   output logic [1:0]         STAGE_REG_OCC,
   output logic [CNT_W-1:0]   STAGE_REG_BUBBLES
);

   occ_state_t         r_state, w_state_next;
   logic               r_in_ready, w_in_ready_next;
   logic [INSTR_W-1:0] r_main_instr, w_main_instr_next;
   logic [PC_W-1:0]    r_main_pc, w_main_pc_next;
   logic [INSTR_W-1:0] r_skid_instr, w_skid_instr_next;
   logic [PC_W-1:0]    r_skid_pc, w_skid_pc_next;

   logic w_out_valid;
   logic w_in_fire;
   logic w_out_fire;

   assign w_out_valid = (r_state != ST_EMPTY);
   assign w_in_fire   = STAGE_REG_IN_VALID & r_in_ready;
   assign w_out_fire  = w_out_valid & STAGE_REG_OUT_READY;

   always_comb begin
      w_state_next      = r_state;
      w_main_instr_next = r_main_instr;
      w_main_pc_next    = r_main_pc;
      w_skid_instr_next = r_skid_instr;
      w_skid_pc_next    = r_skid_pc;

      case (r_state)
         ST_EMPTY: begin
            if (w_in_fire) begin
               w_main_instr_next = STAGE_REG_IN_INSTR;
               w_main_pc_next    = STAGE_REG_IN_PCPLUS4;
               w_state_next      = ST_ONE;
            end
         end
         ST_ONE: begin
            if (w_in_fire && w_out_fire) begin
               w_main_instr_next = STAGE_REG_IN_INSTR;
               w_main_pc_next    = STAGE_REG_IN_PCPLUS4;
            end else if (w_in_fire) begin
               // Downstream stalled: park the new payload behind the main one.
               w_skid_instr_next = STAGE_REG_IN_INSTR;
               w_skid_pc_next    = STAGE_REG_IN_PCPLUS4;
               w_state_next      = ST_FULL;
            end else if (w_out_fire) begin
               // Main data is left as-is; OUT_VALID=0 marks it stale.
               w_state_next = ST_EMPTY;
            end
         end
         ST_FULL: begin
            // in_fire cannot occur here because ready is low in FULL.
            if (w_out_fire) begin
               w_main_instr_next = r_skid_instr;
               w_main_pc_next    = r_skid_pc;
               w_state_next      = ST_ONE;
            end
         end
         default: begin
            w_state_next = ST_EMPTY;
         end
      endcase

      // Flush drops held entries and any same-cycle input; an out_fire this
      // cycle has already been sampled downstream and so stands.
      if (STAGE_REG_FLUSH) begin
         w_state_next      = ST_EMPTY;
         w_main_instr_next = '0;
         w_main_pc_next    = '0;
         w_skid_instr_next = '0;
         w_skid_pc_next    = '0;
      end

      // Ready is computed from the next state so it can be registered.
      w_in_ready_next = (w_state_next != ST_FULL);
   end

   always_ff @(posedge STAGE_REG_CLK) begin
      if (STAGE_REG_RST) begin
         r_state      <= ST_EMPTY;
         r_in_ready   <= 1'b1;
         r_main_instr <= '0;
         r_main_pc    <= '0;
         r_skid_instr <= '0;
         r_skid_pc    <= '0;
      end else begin
         r_state      <= w_state_next;
         r_in_ready   <= w_in_ready_next;
         r_main_instr <= w_main_instr_next;
         r_main_pc    <= w_main_pc_next;
         r_skid_instr <= w_skid_instr_next;
         r_skid_pc    <= w_skid_pc_next;
      end
   end

   sat_counter #(
      .CNT_W (CNT_W)
   ) u_bubble_cnt (
      .i_clk   (STAGE_REG_CLK),
      .i_clr   (STAGE_REG_RST),
      .i_inc   (~w_out_valid),
      .o_count (STAGE_REG_BUBBLES)
   );

   assign STAGE_REG_IN_READY    = r_in_ready;
   assign STAGE_REG_OUT_VALID   = w_out_valid;
   assign STAGE_REG_OUT_INSTR   = r_main_instr;
   assign STAGE_REG_OUT_PCPLUS4 = r_main_pc;
   assign STAGE_REG_OCC         = r_state;

endmodule

// File: tb/tb_stage_reg.sv
// -----------------------------------------------------------------------------
// tb_stage_reg
// Scoreboard bench for stage_reg (CNT_W=4 so bubble saturation is reachable).
// The driver pushes each accepted payload into a queue; a monitor pops and
// compares on every output transfer. Directed checks cover the cycle-exact
// state, reset, flush and bubble counter values.
// -----------------------------------------------------------------------------
module tb_stage_reg;

   localparam int INSTR_W = 32;
   localparam int PC_W    = 32;
   localparam int CNT_W   = 4;

   logic               clk = 1'b0;
   logic               rst;
   logic               flush;
   logic               in_valid;
   logic               in_ready;
   logic [INSTR_W-1:0] in_instr;
   logic [PC_W-1:0]    in_pc;
   logic               out_valid;
   logic               out_ready;
   logic [INSTR_W-1:0] out_instr;
   logic [PC_W-1:0]    out_pc;
   logic [1:0]         occ;
   logic [CNT_W-1:0]   bubbles;

   int checks = 0;
   int errors = 0;
   logic [63:0] sb_q[$];

   always #5 clk = ~clk;

   stage_reg #(
      .INSTR_W (INSTR_W),
      .PC_W    (PC_W),
      .CNT_W   (CNT_W)
   ) dut (
      .STAGE_REG_CLK         (clk),
      .STAGE_REG_RST         (rst),
      .STAGE_REG_FLUSH       (flush),
      .STAGE_REG_IN_VALID    (in_valid),
      .STAGE_REG_IN_READY    (in_ready),
      .STAGE_REG_IN_INSTR    (in_instr),
      .STAGE_REG_IN_PCPLUS4  (in_pc),
      .STAGE_REG_OUT_VALID   (out_valid),
      .STAGE_REG_OUT_READY   (out_ready),
      .STAGE_REG_OUT_INSTR   (out_instr),
      .STAGE_REG_OUT_PCPLUS4 (out_pc),
      .STAGE_REG_OCC         (occ),
      .STAGE_REG_BUBBLES     (bubbles)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // One cycle of stimulus: drive after the edge, record acceptance at the
   // negedge, return 1 time unit after the following rising edge.
   task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                       input logic ordy, input logic fl, input logic rs);
      in_valid  = v;
      in_instr  = ins;
      in_pc     = pc;
      out_ready = ordy;
      flush     = fl;
      rst       = rs;
      @(negedge clk);
      if (v && in_ready && !fl && !rs) begin
         sb_q.push_back({ins, pc});
         $display("in  instr=0x%08h pc=0x%08h", ins, pc);
      end
      @(posedge clk);
      #1;
      if (rs || fl) sb_q.delete();
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
      chk({tag, "_occ"},       64'(occ),       64'd0);
      chk({tag, "_in_ready"},  64'(in_ready),  64'd1);
      chk({tag, "_out_instr"}, 64'(out_instr), 64'd0);
      chk({tag, "_out_pc"},    64'(out_pc),    64'd0);
      chk({tag, "_bubbles"},   64'(bubbles),   64'd0);
   endtask

   // Monitor: every output transfer must match the oldest accepted payload.
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_unexpected actual=0x%08h expected=none at %0t", out_instr, $time);
         end else begin
            logic [63:0] exp_item;
            exp_item = sb_q.pop_front();
            $display("out instr=0x%08h pc=0x%08h", out_instr, out_pc);
            chk("sb_instr", 64'(out_instr), 64'(exp_item[63:32]));
            chk("sb_pc",    64'(out_pc),    64'(exp_item[31:0]));
         end
      end
   end

   localparam logic [31:0] STREAM_I [3] = '{32'h20080005, 32'h20090007, 32'h01095020};
   localparam logic [31:0] STREAM_P [3] = '{32'h4, 32'h8, 32'hC};

   initial begin
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0; out_ready = 1'b0;
      @(posedge clk); #1;

      // Reset held two cycles with traffic offered.
      step(1, 32'hDEADBEEF, 32'h100, 1, 0, 1);
      step(1, 32'hDEADBEEF, 32'h100, 1, 0, 1);
      chk_reset_vals("rst");

      // Streaming: each payload appears one cycle after acceptance.
      for (int i = 0; i < 3; i++) begin
         step(1, STREAM_I[i], STREAM_P[i], 1, 0, 0);
         chk("stream_valid", 64'(out_valid), 64'd1);
         chk("stream_instr", 64'(out_instr), 64'(STREAM_I[i]));
         chk("stream_pc",    64'(out_pc),    64'(STREAM_P[i]));
         chk("stream_occ",   64'(occ),       64'd1);
         chk("stream_ready", 64'(in_ready),  64'd1);
      end
      step(0, 0, 0, 1, 0, 0);
      chk("stream_drain_occ", 64'(occ), 64'd0);

      // Back-pressure: A, B fill the stage; C is refused until space frees.
      step(1, 32'h11111111, 32'h10, 0, 0, 0);
      chk("bp_occ1", 64'(occ), 64'd1);
      step(1, 32'h22222222, 32'h14, 0, 0, 0);
      chk("bp_occ2",   64'(occ),       64'd2);
      chk("bp_ready0", 64'(in_ready),  64'd0);
      chk("bp_hold_a", 64'(out_instr), 64'h11111111);
      step(1, 32'h33333333, 32'h18, 0, 0, 0);
      chk("bp_c_refused", 64'(occ),       64'd2);
      chk("bp_hold_a2",   64'(out_instr), 64'h11111111);
      step(1, 32'h33333333, 32'h18, 1, 0, 0);
      chk("bp_b_out",  64'(out_instr), 64'h22222222);
      chk("bp_occ_r",  64'(occ),       64'd1);
      chk("bp_ready1", 64'(in_ready),  64'd1);
      step(1, 32'h33333333, 32'h18, 1, 0, 0);
      chk("bp_c_out", 64'(out_instr), 64'h33333333);
      step(0, 0, 0, 1, 0, 0);
      chk("bp_drain_occ", 64'(occ), 64'd0);

      // Flush while FULL with an input offered.
      step(1, 32'h44444444, 32'h20, 0, 0, 0);
      step(1, 32'h55555555, 32'h24, 0, 0, 0);
      chk("fl_pre_occ", 64'(occ), 64'd2);
      step(1, 32'h66666666, 32'h28, 0, 1, 0);
      chk("fl_occ",      64'(occ),       64'd0);
      chk("fl_valid",    64'(out_valid), 64'd0);
      chk("fl_instr",    64'(out_instr), 64'd0);
      chk("fl_pc",       64'(out_pc),    64'd0);
      chk("fl_in_ready", 64'(in_ready),  64'd1);
      step(0, 0, 0, 1, 0, 0);
      chk("fl_no_deliver", 64'(out_valid), 64'd0);

      // RST and FLUSH together with in_fire.
      step(1, 32'h77777777, 32'h30, 0, 0, 0);
      step(1, 32'h88888888, 32'h34, 0, 1, 1);
      chk_reset_vals("rstfl");

      // In ONE, simultaneous in_fire and out_fire.
      step(1, 32'h99999999, 32'h40, 0, 0, 0);
      step(1, 32'hAAAAAAAA, 32'h44, 1, 0, 0);
      chk("sim_occ",   64'(occ),       64'd1);
      chk("sim_instr", 64'(out_instr), 64'hAAAAAAAA);
      chk("sim_pc",    64'(out_pc),    64'h44);
      step(0, 0, 0, 1, 0, 0);

      // Bubbles: count idle cycles, freeze while valid, saturate, clear.
      step(0, 0, 0, 0, 0, 1);
      chk("bub_clr", 64'(bubbles), 64'd0);
      for (int k = 1; k <= 3; k++) step(0, 0, 0, 0, 0, 0);
      chk("bub_3", 64'(bubbles), 64'd3);
      step(1, 32'hBBBBBBBB, 32'h50, 0, 0, 0);
      chk("bub_4", 64'(bubbles), 64'd4);
      step(0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0);
      chk("bub_frozen", 64'(bubbles), 64'd4);
      step(0, 0, 0, 1, 0, 0);
      chk("bub_frozen2", 64'(bubbles), 64'd4);
      step(0, 0, 0, 0, 0, 1);
      for (int k = 1; k <= 20; k++) begin
         step(0, 0, 0, 0, 0, 0);
         chk("bub_idle", 64'(bubbles), 64'((k > 15) ? 15 : k));
      end
      step(0, 0, 0, 0, 1, 0);
      chk("bub_flush_sat", 64'(bubbles), 64'd15);
      step(0, 0, 0, 0, 0, 1);
      chk("bub_rst", 64'(bubbles), 64'd0);

      chk("sb_empty", 64'(sb_q.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
